// File: rtl/bcd_display_scan_pkg.sv
// Shared definitions for the multiplexed 7-segment display blocks:
// segment bit order, slot count/encoding and the nibble-to-segment table.
package bcd_display_scan_pkg;

    // Number of multiplexed digit slots on the display.
    localparam int NUM_SLOTS = 3;

    // Segment vector layout: seg[6:0] = {g,f,e,d,c,b,a}.
    localparam int SEG_W = 7;
    typedef enum logic [2:0] {
        SEG_A = 3'd0,
        SEG_B = 3'd1,
        SEG_C = 3'd2,
        SEG_D = 3'd3,
        SEG_E = 3'd4,
        SEG_F = 3'd5,
        SEG_G = 3'd6
    } seg_bit_e;

    // Slot index encoding; 2'b11 is never entered.
    typedef enum logic [1:0] {
        SLOT0 = 2'd0,
        SLOT1 = 2'd1,
        SLOT2 = 2'd2
    } slot_e;

    // Active-high segment codes. Non-decimal nibbles show a dash (g only).
    localparam logic [SEG_W-1:0] SEG_DASH = 7'h40;
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, // F..A
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,                          // 9..5
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F                           // 4..0
    };

    // One-hot anode pattern for a slot (active-high form).
    function automatic logic [NUM_SLOTS-1:0] slot_onehot(input slot_e s);
        return 3'b001 << s;
    endfunction

endpackage

// File: rtl/bcd_display_scan_bcd_to_seg.sv
// Combinational nibble to active-high 7-segment decoder.
module bcd_to_seg
    import bcd_display_scan_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg
);

    // Straight table lookup; A..F fall on the dash entries.
    always_comb begin
        seg = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Three-digit multiplexed 7-segment driver with per-frame input snapshot,
// leading-cycle anti-ghost blanking and blanking of unentered digits.
module bcd_display_scan
    import bcd_display_scan_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [11:0]          bcd,
    input  logic [1:0]           ndigits,
    output logic [SEG_W-1:0]     seg,
    output logic [NUM_SLOTS-1:0] an,
    output logic                 frame_tick
);

    localparam int                   CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]        CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [SEG_W-1:0]     SEG_OFF  = SEG_ACTIVE_LOW ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
    localparam logic [NUM_SLOTS-1:0] AN_OFF   = AN_ACTIVE_LOW ? {NUM_SLOTS{1'b1}} : {NUM_SLOTS{1'b0}};

    logic [CW-1:0]        cnt_q, cnt_d;
    slot_e                idx_q, idx_d;
    logic [11:0]          shadow_bcd_q, shadow_bcd_d;
    logic [1:0]           shadow_n_q, shadow_n_d;
    logic                 frame_tick_q, frame_tick_d;
    logic [NUM_SLOTS-1:0] an_q, an_d;
    logic [SEG_W-1:0]     seg_q, seg_d;

    logic                 tick;
    logic                 wrap;
    logic                 lit;
    logic [SEG_W-1:0]     sel_seg;
    logic [SEG_W-1:0]     digit_seg [NUM_SLOTS];

    // One decoder per digit, fed from the snapshot that will be live next cycle.
    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_dec
            bcd_to_seg u_dec (
                .nibble (shadow_bcd_d[gi*4 +: 4]),
                .seg    (digit_seg[gi])
            );
        end
    endgenerate

    // Next-state: divider, slot sequence, snapshot, and outputs from the next cnt/idx.
    always_comb begin
        tick    = (cnt_q == CNT_LAST);
        cnt_d   = tick ? '0 : cnt_q + CW'(1);
        idx_d   = idx_q;
        if (tick) begin
            case (idx_q)
                SLOT0:   idx_d = SLOT1;
                SLOT1:   idx_d = SLOT2;
                default: idx_d = SLOT0;
            endcase
        end
        wrap         = tick && (idx_q == SLOT2);
        shadow_bcd_d = wrap ? bcd : shadow_bcd_q;
        shadow_n_d   = wrap ? ndigits : shadow_n_q;
        frame_tick_d = wrap;

        case (idx_d)
            SLOT0:   sel_seg = digit_seg[0];
            SLOT1:   sel_seg = digit_seg[1];
            default: sel_seg = digit_seg[2];
        endcase

        // Dark on the first cycle of a slot and for digits not yet entered.
        lit   = (cnt_d != '0) && (2'(idx_d) < shadow_n_d);
        an_d  = (lit ? slot_onehot(idx_d) : '0) ^ AN_OFF;
        seg_d = (lit ? sel_seg : '0) ^ SEG_OFF;
    end

    // State and output registers with synchronous reset to a dark display.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= SLOT0;
            shadow_bcd_q <= '0;
            shadow_n_q   <= '0;
            frame_tick_q <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_bcd_q <= shadow_bcd_d;
            shadow_n_q   <= shadow_n_d;
            frame_tick_q <= frame_tick_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with REFRESH_DIV=4; one instance per
// polarity setting, both driven by the same stimulus.
module tb_bcd_display_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] bcd;
    logic [1:0]  ndigits;

    logic [6:0]  seg_p, seg_n;
    logic [2:0]  an_p, an_n;
    logic        ft_p, ft_n;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    bcd_display_scan #(
        .REFRESH_DIV    (4),
        .SEG_ACTIVE_LOW (1'b0),
        .AN_ACTIVE_LOW  (1'b0)
    ) dut_hi (
        .clk        (clk),
        .rst        (rst),
        .bcd        (bcd),
        .ndigits    (ndigits),
        .seg        (seg_p),
        .an         (an_p),
        .frame_tick (ft_p)
    );

    bcd_display_scan #(
        .REFRESH_DIV    (4),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut_lo (
        .clk        (clk),
        .rst        (rst),
        .bcd        (bcd),
        .ndigits    (ndigits),
        .seg        (seg_n),
        .an         (an_n),
        .frame_tick (ft_n)
    );

    typedef struct {
        logic [11:0] bcd;
        logic [1:0]  n;
        logic [6:0]  e0;
        logic [6:0]  e1;
        logic [6:0]  e2;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int k, input logic [6:0] act, input logic [6:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s k=%0d actual=%h expected=%h", name, k, act, exp);
        end
    endtask

    // Advance one clock; k is the cycle number since the last reset edge.
    // e0..e2 are the active-high codes of the live snapshot, n its digit count.
    task automatic step_check(input int k, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input int n);
        int         slot;
        int         c;
        logic [2:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_ft;
        @(posedge clk);
        #1;
        slot    = (k % 12) / 4;
        c       = k % 4;
        exp_an  = 3'b000;
        exp_seg = 7'h00;
        if (c != 0 && slot < n) begin
            exp_an  = 3'b001 << slot;
            exp_seg = (slot == 0) ? e0 : (slot == 1) ? e1 : e2;
        end
        exp_ft = (k > 0) && (k % 12 == 0);
        chk("an_hi",  k, {4'b0, an_p},  {4'b0, exp_an});
        chk("seg_hi", k, seg_p,         exp_seg);
        chk("an_lo",  k, {4'b0, an_n},  {4'b0, ~exp_an});
        chk("seg_lo", k, seg_n,         ~exp_seg);
        chk("ft_hi",  k, {6'b0, ft_p},  {6'b0, exp_ft});
        chk("ft_lo",  k, {6'b0, ft_n},  {6'b0, exp_ft});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step_check(0, 7'h00, 7'h00, 7'h00, 0);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{12'h321, 2'd3, 7'h06, 7'h5B, 7'h4F};
        vecs[1] = '{12'h987, 2'd1, 7'h07, 7'h7F, 7'h6F};
        vecs[2] = '{12'h0FA, 2'd3, 7'h40, 7'h40, 7'h3F};
        vecs[3] = '{12'h008, 2'd1, 7'h7F, 7'h3F, 7'h3F};
        vecs[4] = '{12'h540, 2'd2, 7'h3F, 7'h66, 7'h6D};
        vecs[5] = '{12'h765, 2'd3, 7'h6D, 7'h7D, 7'h07};
        vecs[6] = '{12'h098, 2'd3, 7'h7F, 7'h6F, 7'h3F};
        vecs[7] = '{12'h8BC, 2'd3, 7'h40, 7'h40, 7'h7F};
        vecs[8] = '{12'h999, 2'd0, 7'h6F, 7'h6F, 7'h6F};

        rst     = 1'b1;
        bcd     = 12'h000;
        ndigits = 2'd0;
        repeat (2) @(posedge clk);
        #1;

        // Table: blank first frame, snapshot at cycle 12, then one full frame.
        for (int i = 0; i < 9; i++) begin
            bcd     = vecs[i].bcd;
            ndigits = vecs[i].n;
            $display("[TB] vector %0d bcd=%h ndigits=%0d", i, vecs[i].bcd, vecs[i].n);
            do_reset();
            for (int k = 1; k <= 12; k++)
                step_check(k, 7'h00, 7'h00, 7'h00, 0);
            for (int k = 13; k <= 24; k++)
                step_check(k, vecs[i].e0, vecs[i].e1, vecs[i].e2, int'(vecs[i].n));
        end

        // Mid-frame input change: current frame unaffected, next frame updated.
        $display("[TB] sequence: bcd change during slot1");
        bcd     = 12'h321;
        ndigits = 2'd3;
        do_reset();
        for (int k = 1; k <= 12; k++)
            step_check(k, 7'h00, 7'h00, 7'h00, 0);
        for (int k = 13; k <= 24; k++) begin
            if (k == 18) begin
                bcd     = 12'h654;
                ndigits = 2'd1;
            end
            if (k == 22) ndigits = 2'd3;
            step_check(k, 7'h06, 7'h5B, 7'h4F, 3);
        end
        for (int k = 25; k <= 45; k++)
            step_check(k, 7'h66, 7'h6D, 7'h7D, 3);

        // Reset during slot2: immediate blank, snapshot discarded, blank frame again.
        $display("[TB] sequence: reset during slot2");
        do_reset();
        for (int k = 1; k <= 12; k++)
            step_check(k, 7'h00, 7'h00, 7'h00, 0);
        for (int k = 13; k <= 24; k++)
            step_check(k, 7'h66, 7'h6D, 7'h7D, 3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
Display-side consumer of the keypad encoder's 12-bit packed BCD word and entered-digit count. Drives a 3-digit multiplexed 7-segment display: a one-hot anode decoder plus a BCD-to-segment decoder, time-multiplexed by a refresh divider. Digits not yet entered are blanked. Input is snapshotted once per frame so a digit that changes mid-scan cannot tear the frame.

Parameters:
REFRESH_DIV, 50000, clk cycles per digit slot; legal range 2 to 2^20.
SEG_ACTIVE_LOW, 1, 1 = seg outputs driven low-true.
AN_ACTIVE_LOW, 1, 1 = an outputs driven low-true.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
bcd  in  12  packed digits: [3:0] = digit0 (first entered), [7:4] = digit1, [11:8] = digit2
ndigits  in  2  number of valid digits, 0..3
seg  out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
an  out  3  one-hot digit enable, an[i] = digit i, polarity per AN_ACTIVE_LOW
frame_tick  out  1  one-cycle pulse on the edge the input snapshot is taken

Behaviour:
- Reset is synchronous; all state and outputs are registered.
- Reset values: divider cnt = 0, slot idx = 0, shadow_bcd = 0, shadow_n = 0, frame_tick = 0, an = all off, seg = all off. "Off" is the inactive level for the configured polarity.
- Divider: cnt counts 0..REFRESH_DIV-1 and wraps. tick is asserted when cnt == REFRESH_DIV-1.
- Slot sequence on tick: idx advances 0 -> 1 -> 2 -> 0. No other transitions occur.
- Snapshot: on the tick where idx wraps 2 -> 0:
  - shadow_bcd <= bcd, shadow_n <= ndigits, frame_tick <= 1 for exactly one cycle.
  - The first snapshot happens at the end of the first full frame after reset, so the display is blank until then.
- Anti-ghost blanking: during the first cycle of every slot (cnt == 0), an = all off. For cnt >= 1, an drives the one-hot value for idx, provided the digit is enabled.
- Digit enable: digit i is enabled iff i < shadow_n. A disabled digit keeps an off for the whole slot.
- Segment decode, active-high form before polarity is applied:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibble values A..F show a dash (40).
  - seg = off whenever an is off.
- Latency: seg and an are registered from the idx/cnt values of the next cycle. They change on the same edge as idx/cnt, with no added pipeline cycle.
- bcd and ndigits may change on any cycle. Only values present on the snapshot edge are displayed.
- Reset asserted mid-frame: on the next edge, return to the reset state and discard the current snapshot.
- One full frame lasts 3 * REFRESH_DIV cycles.

Decomposition:
- Shared display package holds:
  - the 16-entry segment table constants (digits 0-9 and the dash code);
  - the segment bit-order definition;
  - the slot count constant (3).
- One natural sub-module, bcd_to_seg: combinational nibble-to-7-segment decoder, reusable by other display blocks.
- Divider, slot FSM, snapshot and polarity logic stay in the top module.

Test Plan (REFRESH_DIV=4, both polarities 0 unless stated):
1. Reset release with bcd=0x321, ndigits=3 -> an=000 and seg=00 for the first 12 cycles. frame_tick pulses at cycle 12. Next frame: slot0 an=001, seg=06; slot1 an=010, seg=5B; slot2 an=100, seg=4F. Each slot has an=000 in its first cycle.
2. ndigits=1, bcd=0x987 -> only slot0 lights (an=001, seg=07). Slots 1 and 2 keep an=000 and seg=00.
3. Change bcd from 0x321 to 0x654 mid-frame in slot1 -> the current frame still shows 1,2,3. The following frame shows 4,5,6 (seg 66, 6D, 7D).
4. bcd=0x0FA, ndigits=3 -> digit0 and digit1 show seg=40 (dash), digit2 shows seg=3F.
5. Assert rst for 1 cycle during slot2 -> the next cycle has an=000, seg=00, cnt=0, idx=0. The display stays blank until the next frame_tick, 12 cycles later.
6. SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1, bcd=0x008, ndigits=1 -> slot0 an=110, seg=0x00. The blank cycle drives an=111, seg=7F.
